// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD command sequencer.
package lcd_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_POWERON,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT,
      ST_IDLE
   } lcd_state_e;

   // One byte on the LCD bus: register select plus data
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_byte_t;

   // Power-up command list: 8-bit/2-line x2, display on, clear, entry mode
   localparam int LCD_INIT_LEN = 5;
   localparam logic [LCD_INIT_LEN-1:0][7:0] LCD_INIT_ROM =
      {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38};

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   // Clear and home (0x02/0x03 are both "home") need the long settle time
   function automatic logic needs_long_wait(input lcd_byte_t b);
      return !b.rs && ((b.data == LCD_CMD_CLEAR) ||
                       (b.data == LCD_CMD_HOME)  ||
                       (b.data == 8'h03));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Per-state delay timer: cleared on state entry, counts cycles spent in the
// state and flags the last one (elapsed == limit). Saturates at the limit.
module lcd_cycle_timer #(
   parameter int CNT_W = 8
) (
   input  logic             fpga_clk_i,
   input  logic             fpga_reset_i,
   input  logic             clr,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   // Elapsed-cycle counter; reset and clear both restart it at zero
   always_ff @(posedge fpga_clk_i) begin
      if (!fpga_reset_i)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (cnt != limit)
         cnt <= cnt + CNT_W'(1);
   end

   assign done = (cnt == limit);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style 8-bit LCD bus sequencer: power-on reset hold, fixed init
// command list, then single-byte writes from one valid/ready requester with
// setup / enable-pulse / settle timing around each byte.
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES        = 4,
   parameter int EN_HIGH_CYCLES      = 25,
   parameter int CMD_WAIT_CYCLES     = 2000,
   parameter int CLEAR_WAIT_CYCLES   = 82000,
   parameter int POWERON_WAIT_CYCLES = 750000
) (
   input  logic       fpga_clk_i,
   input  logic       fpga_reset_i,
   input  logic       wr_valid_i,
   input  logic       wr_rs_i,
   input  logic [7:0] wr_data_i,
   output logic       wr_ready_o,
   output logic       init_done_o,
   output logic [7:0] lcd_data_o,
   output logic       lcd_rs_o,
   output logic       lcd_enable_o,
   output logic       lcd_reset_o
);

   localparam int MAX_DLY = max_int(max_int(max_int(SETUP_CYCLES, EN_HIGH_CYCLES),
                                            max_int(CMD_WAIT_CYCLES, CLEAR_WAIT_CYCLES)),
                                    POWERON_WAIT_CYCLES);
   localparam int CNT_W = $clog2(MAX_DLY) + 1;
   localparam logic [2:0] LAST_IDX = 3'(LCD_INIT_LEN - 1);

   lcd_state_e       state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic             done_q, done_d;
   lcd_byte_t        cur_q, cur_d;
   logic [CNT_W-1:0] tmr_limit;
   logic             tmr_clr;
   logic             tmr_done;

   // Duration of the current state, minus one (timer counts from zero)
   always_comb begin
      tmr_limit = '0;
      unique case (state_q)
         ST_POWERON: tmr_limit = CNT_W'(POWERON_WAIT_CYCLES - 1);
         ST_SETUP:   tmr_limit = CNT_W'(SETUP_CYCLES - 1);
         ST_PULSE:   tmr_limit = CNT_W'(EN_HIGH_CYCLES - 1);
         ST_WAIT:    tmr_limit = needs_long_wait(cur_q) ? CNT_W'(CLEAR_WAIT_CYCLES - 1)
                                                        : CNT_W'(CMD_WAIT_CYCLES - 1);
         default:    tmr_limit = '0;
      endcase
   end

   // Next state, init index, sticky done flag and the byte to present
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = done_q;
      cur_d   = cur_q;
      unique case (state_q)
         ST_POWERON: begin
            if (tmr_done) begin
               state_d = ST_SETUP;
               idx_d   = '0;
               cur_d   = '{rs: 1'b0, data: LCD_INIT_ROM[0]};
            end
         end
         ST_SETUP: begin
            if (tmr_done)
               state_d = ST_PULSE;
         end
         ST_PULSE: begin
            if (tmr_done)
               state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (tmr_done) begin
               if (done_q) begin
                  state_d = ST_IDLE;
               end else if (idx_q < LAST_IDX) begin
                  state_d = ST_SETUP;
                  idx_d   = idx_q + 3'd1;
                  cur_d   = '{rs: 1'b0, data: LCD_INIT_ROM[idx_q + 3'd1]};
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (wr_valid_i) begin
               state_d = ST_SETUP;
               cur_d   = '{rs: wr_rs_i, data: wr_data_i};
            end
         end
         default: state_d = ST_POWERON;
      endcase
   end

   // Restart the timer on every state change; keep it parked while idle
   assign tmr_clr    = (state_d != state_q) || (state_q == ST_IDLE);
   assign wr_ready_o = (state_q == ST_IDLE);

   lcd_cycle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .fpga_clk_i   (fpga_clk_i),
      .fpga_reset_i (fpga_reset_i),
      .clr          (tmr_clr),
      .limit        (tmr_limit),
      .done         (tmr_done)
   );

   // State and registered pin drivers; strobes decoded from the next state
   always_ff @(posedge fpga_clk_i) begin
      if (!fpga_reset_i) begin
         state_q      <= ST_POWERON;
         idx_q        <= '0;
         done_q       <= 1'b0;
         cur_q        <= '0;
         lcd_enable_o <= 1'b0;
         lcd_reset_o  <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         done_q       <= done_d;
         cur_q        <= cur_d;
         lcd_enable_o <= (state_d == ST_PULSE);
         lcd_reset_o  <= (state_d == ST_POWERON);
      end
   end

   assign init_done_o = done_q;
   assign lcd_data_o  = cur_q.data;
   assign lcd_rs_o    = cur_q.rs;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench: scoreboard of expected bus bytes popped on each enable
// pulse, table of user writes, hand sequences for timing corner cases.
module tb_lcd_cmd_sequencer;

   localparam int S   = 2;
   localparam int E   = 3;
   localparam int W   = 5;
   localparam int CLR = 9;
   localparam int PON = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       ready, init_done, lcd_rs, lcd_en, lcd_rst;
   logic [7:0] lcd_data;

   lcd_cmd_sequencer #(
      .SETUP_CYCLES        (S),
      .EN_HIGH_CYCLES      (E),
      .CMD_WAIT_CYCLES     (W),
      .CLEAR_WAIT_CYCLES   (CLR),
      .POWERON_WAIT_CYCLES (PON)
   ) dut (
      .fpga_clk_i   (clk),
      .fpga_reset_i (rst_n),
      .wr_valid_i   (valid),
      .wr_rs_i      (wr_rs),
      .wr_data_i    (wr_data),
      .wr_ready_o   (ready),
      .init_done_o  (init_done),
      .lcd_data_o   (lcd_data),
      .lcd_rs_o     (lcd_rs),
      .lcd_enable_o (lcd_en),
      .lcd_reset_o  (lcd_rst)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         wt;
   } exp_t;

   exp_t sb_q[$];
   bit   mon_en = 1'b0;
   int   pulses = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Bus monitor: each enable rise pops the next expected byte; widths and
   // gaps around the pulse are measured against the configured timing.
   initial begin
      logic en_d, rdy_d;
      bit   pend;
      int   rise_c, fall_c, cur_wt, pend_wt;
      en_d = 1'b0; rdy_d = 1'b0; pend = 1'b0;
      rise_c = 0; fall_c = 0; cur_wt = 0; pend_wt = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            pend = 1'b0;
         end else begin
            if (lcd_en && !en_d) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_pulse", {24'h0, lcd_data}, 32'hFFFF);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  chk("pulse_data", {24'h0, lcd_data}, {24'h0, e.data});
                  chk("pulse_rs", {31'h0, lcd_rs}, {31'h0, e.rs});
                  cur_wt = e.wt;
               end
               if (pend) chk("gap_to_next_pulse", cyc - fall_c, pend_wt + S);
               pend   = 1'b0;
               rise_c = cyc;
               pulses++;
            end
            if (!lcd_en && en_d) begin
               chk("enable_width", cyc - rise_c, E);
               fall_c  = cyc;
               pend    = 1'b1;
               pend_wt = cur_wt;
            end
            if (ready && !rdy_d && pend) begin
               chk("post_pulse_wait", cyc - fall_c, pend_wt);
               pend = 1'b0;
            end
         end
         en_d  = lcd_en;
         rdy_d = ready;
      end
   end

   // Called at a negedge; returns at the first negedge with ready high
   task automatic wait_ready(input string nm);
      int t;
      t = 0;
      while (!ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!ready) chk(nm, 0, 1);
   endtask

   // Present a byte and hold it until accepted; returns one cycle later
   task automatic accept(input logic rs, input logic [7:0] d, input int wt, output int acc);
      int t;
      t = 0;
      wr_rs = rs; wr_data = d; valid = 1'b1;
      while (!ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!ready) chk("accept_timeout", 0, 1);
      acc = cyc;
      sb_q.push_back('{rs, d, wt});
      @(negedge clk);
      valid = 1'b0;
   endtask

   // Release reset and follow power-on hold plus the five-command init
   task automatic run_init();
      int t, mism;
      sb_q.push_back('{1'b0, 8'h38, W});
      sb_q.push_back('{1'b0, 8'h38, W});
      sb_q.push_back('{1'b0, 8'h0C, W});
      sb_q.push_back('{1'b0, 8'h01, CLR});
      sb_q.push_back('{1'b0, 8'h06, W});
      pulses = 0;
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      for (int j = 0; j <= PON; j++) begin
         if (j > 0) @(negedge clk);
         chk($sformatf("poweron_rst_c%0d", j), {31'h0, lcd_rst}, {31'h0, (j < PON)});
         chk($sformatf("poweron_en_c%0d", j), {31'h0, lcd_en}, 0);
         chk($sformatf("poweron_rdy_c%0d", j), {31'h0, ready}, 0);
      end
      t = PON; mism = 0;
      while (!ready && t < 400) begin
         @(negedge clk);
         t++;
         if (init_done !== ready) mism++;
      end
      // 10-cycle hold, four 10-cycle entries, one 14-cycle clear entry
      chk("init_ready_cycle", t, 64);
      chk("init_done_with_ready", mism, 0);
      chk("init_done_set", {31'h0, init_done}, 1);
      chk("init_pulse_count", pulses, 5);
      chk("init_sb_empty", sb_q.size(), 0);
   endtask

   initial begin
      exp_t vecs[8];
      int   c0, c1, c2, c3, t;

      vecs[0] = '{1'b0, 8'h01, CLR};
      vecs[1] = '{1'b0, 8'h04, W};
      vecs[2] = '{1'b0, 8'h02, CLR};
      vecs[3] = '{1'b0, 8'h03, CLR};
      vecs[4] = '{1'b1, 8'h01, W};
      vecs[5] = '{1'b0, 8'h00, W};
      vecs[6] = '{1'b1, 8'hFF, W};
      vecs[7] = '{1'b1, 8'h5A, W};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_lcd_reset", {31'h0, lcd_rst}, 1);
      chk("rst_enable", {31'h0, lcd_en}, 0);
      chk("rst_data", {24'h0, lcd_data}, 0);
      chk("rst_rs", {31'h0, lcd_rs}, 0);
      chk("rst_ready", {31'h0, ready}, 0);
      chk("rst_init_done", {31'h0, init_done}, 0);

      run_init();

      // Data write: accepted at edge k, cycle-exact view of k+1 .. k+11
      wr_rs = 1'b1; wr_data = 8'h41; valid = 1'b1;
      chk("dw_ready_k", {31'h0, ready}, 1);
      sb_q.push_back('{1'b1, 8'h41, W});
      for (int j = 1; j <= S + E + W + 1; j++) begin
         @(negedge clk);
         if (j == 1) begin
            valid = 1'b0;
            chk("dw_data_k1", {24'h0, lcd_data}, 32'h41);
            chk("dw_rs_k1", {31'h0, lcd_rs}, 1);
         end
         chk($sformatf("dw_en_k%0d", j), {31'h0, lcd_en}, {31'h0, (j >= S + 1 && j <= S + E)});
         chk($sformatf("dw_rdy_k%0d", j), {31'h0, ready}, {31'h0, (j == S + E + W + 1)});
      end

      // Table of user bytes: wait class and idle hold of data/RS
      for (int i = 0; i < 8; i++) begin
         accept(vecs[i].rs, vecs[i].data, vecs[i].wt, c0);
         wait_ready($sformatf("vec%0d_ready_timeout", i));
         chk($sformatf("vec%0d_idle_data", i), {24'h0, lcd_data}, {24'h0, vecs[i].data});
         chk($sformatf("vec%0d_idle_rs", i), {31'h0, lcd_rs}, {31'h0, vecs[i].rs});
      end

      // Busy hold: valid held while busy, then back-to-back second byte
      accept(1'b1, 8'h20, W, c0);
      accept(1'b1, 8'h48, W, c1);
      accept(1'b1, 8'h49, W, c2);
      chk("busy_accept_gap", c1 - c0, S + E + W + 1);
      chk("b2b_accept_gap", c2 - c1, S + E + W + 1);
      wait_ready("busy_ready_timeout");
      chk("busy_sb_empty", sb_q.size(), 0);

      // Reset in the middle of an enable pulse
      accept(1'b0, 8'h04, W, c3);
      t = 0;
      while (!lcd_en && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("mid_reset_reached_pulse", {31'h0, lcd_en}, 1);
      rst_n  = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      chk("mid_reset_enable", {31'h0, lcd_en}, 0);
      chk("mid_reset_lcd_reset", {31'h0, lcd_rst}, 1);
      chk("mid_reset_init_done", {31'h0, init_done}, 0);
      chk("mid_reset_ready", {31'h0, ready}, 0);
      chk("mid_reset_data", {24'h0, lcd_data}, 0);
      sb_q.delete();
      run_init();

      accept(1'b1, 8'h33, W, c0);
      wait_ready("final_ready_timeout");
      chk("final_sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
